// File: rtl/sync_fifo_rr_ctrl.sv
// Round-robin write arbiter and read-ahead drain controller for one external synchronous FIFO.
// Producers share the FIFO write port; a 2-entry output buffer presents words on a valid/ready port.
module sync_fifo_rr_ctrl #(
    parameter int AW   = 8,
    parameter int DW   = 16,
    parameter int NREQ = 4
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    input  logic [NREQ-1:0]      i_REQ,
    input  logic [NREQ*DW-1:0]   i_REQ_DATA,
    output logic [NREQ-1:0]      o_GNT,
    output logic                 o_FIFO_WEN,
    output logic [DW-1:0]        o_FIFO_DI,
    output logic                 o_FIFO_REN,
    input  logic [DW-1:0]        i_FIFO_DO,
    input  logic [AW:0]          i_FIFO_CNTR,
    output logic                 o_VALID,
    output logic [DW-1:0]        o_DATA,
    input  logic                 i_READY,
    output logic [AW+1:0]        o_LEVEL
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] req_data [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req_slice
            assign req_data[gi] = i_REQ_DATA[gi*DW +: DW];
        end
    endgenerate

    // ---------------- write side: round-robin arbiter ----------------
    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] cand;
    logic          gnt_any;
    logic          fifo_full;
    int            arb_sum;

    // Count of the FIFO is the only full indication; a same-cycle read is not credited.
    assign fifo_full = (i_FIFO_CNTR == FULL_CNT);

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = ptr_reg;
        arb_sum = 0;
        cand    = '0;
        for (int off = 1; off <= NREQ; off++) begin
            arb_sum = int'(ptr_reg) + off;
            if (arb_sum >= NREQ) begin
                arb_sum = arb_sum - NREQ;
            end
            cand = PW'(arb_sum);
            if (!gnt_any && !fifo_full && !i_RST && i_REQ[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign o_GNT      = NREQ'(gnt_any) << gnt_idx;
    assign o_FIFO_WEN = gnt_any;
    assign o_FIFO_DI  = gnt_any ? req_data[gnt_idx] : '0;
    assign ptr_next   = gnt_any ? gnt_idx : ptr_reg;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            ptr_reg <= PW'(NREQ - 1);
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    // ---------------- read side: 2-entry output buffer ----------------
    logic [1:0]    occ_reg;
    logic [1:0]    occ_next;
    logic [1:0]    occ_after_pop;
    logic          pend_reg;
    logic          pop;
    logic          ren;
    logic [DW-1:0] buf_reg  [2];
    logic [DW-1:0] buf_next [2];

    assign o_VALID       = (occ_reg != 2'd0);
    assign o_DATA        = buf_reg[0];
    assign pop           = o_VALID && i_READY;
    assign occ_after_pop = occ_reg - {1'b0, pop};

    // Only issue a read when the word it returns next cycle is certain to find a free entry.
    assign ren        = !i_RST && (i_FIFO_CNTR != '0) &&
                        (({1'b0, occ_after_pop} + {2'b00, pend_reg}) <= 3'd1);
    assign o_FIFO_REN = ren;
    assign occ_next   = occ_after_pop + {1'b0, pend_reg};

    always_comb begin
        buf_next[0] = buf_reg[0];
        buf_next[1] = buf_reg[1];
        if (pop) begin
            buf_next[0] = buf_reg[1];
            buf_next[1] = '0;
        end
        if (pend_reg) begin
            if (occ_after_pop == 2'd0) begin
                buf_next[0] = i_FIFO_DO;
            end else begin
                buf_next[1] = i_FIFO_DO;
            end
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            occ_reg    <= 2'd0;
            pend_reg   <= 1'b0;
            buf_reg[0] <= '0;
            buf_reg[1] <= '0;
        end else begin
            occ_reg    <= occ_next;
            pend_reg   <= ren;
            buf_reg[0] <= buf_next[0];
            buf_reg[1] <= buf_next[1];
        end
    end

    assign o_LEVEL = (AW+2)'(i_FIFO_CNTR) + (AW+2)'(occ_reg) + (AW+2)'(pend_reg);

endmodule

// File: tb/tb_sync_fifo_rr_ctrl.sv
// Randomised and directed bench for sync_fifo_rr_ctrl with a behavioural FIFO and a queue-based
// scoreboard; outputs are compared every falling edge.
module tb_sync_fifo_rr_ctrl;

    localparam int AW    = 2;
    localparam int DW    = 16;
    localparam int NREQ  = 4;
    localparam int DEPTH = 1 << AW;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     gnt;
    logic                fifo_wen;
    logic [DW-1:0]       fifo_di;
    logic                fifo_ren;
    logic [DW-1:0]       fifo_do;
    logic [AW:0]         fifo_cnt;
    logic                valid;
    logic [DW-1:0]       data;
    logic                ready;
    logic [AW+1:0]       level;

    sync_fifo_rr_ctrl #(.AW(AW), .DW(DW), .NREQ(NREQ)) dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_REQ       (req),
        .i_REQ_DATA  (req_data),
        .o_GNT       (gnt),
        .o_FIFO_WEN  (fifo_wen),
        .o_FIFO_DI   (fifo_di),
        .o_FIFO_REN  (fifo_ren),
        .i_FIFO_DO   (fifo_do),
        .i_FIFO_CNTR (fifo_cnt),
        .o_VALID     (valid),
        .o_DATA      (data),
        .i_READY     (ready),
        .o_LEVEL     (level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Unguarded external FIFO, registered read data, same reset as the controller.
    logic [DW-1:0] fmem [DEPTH];
    logic [AW-1:0] fwp;
    logic [AW-1:0] frp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fwp      <= '0;
            frp      <= '0;
            fifo_cnt <= '0;
            fifo_do  <= '0;
        end else begin
            if (fifo_wen) begin
                fmem[fwp] <= fifo_di;
                fwp       <= fwp + AW'(1);
            end
            if (fifo_ren) begin
                fifo_do <= fmem[frp];
                frp     <= frp + AW'(1);
            end
            fifo_cnt <= fifo_cnt + (AW+1)'(fifo_wen) - (AW+1)'(fifo_ren);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Producer backlogs: each producer holds its request while it has a word waiting.
    logic [DW-1:0]   pmem [NREQ][64];
    int              phead [NREQ];
    int              ptail [NREQ];
    logic [NREQ-1:0] g_lat;
    int              rdy_mode;

    task automatic push_word(input int k, input logic [DW-1:0] d);
        pmem[k][ptail[k] % 64] = d;
        ptail[k]++;
    endtask

    task automatic clear_producers();
        for (int k = 0; k < NREQ; k++) begin
            phead[k] = 0;
            ptail[k] = 0;
        end
    endtask

    function automatic bit producers_empty();
        bit e;
        e = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            if (phead[k] != ptail[k]) e = 1'b0;
        end
        return e;
    endfunction

    task automatic cycle();
        logic [NREQ*DW-1:0] v;
        logic [NREQ-1:0]    r;
        int                 gl;
        @(posedge clk);
        #1;
        gl = int'(g_lat);
        for (int k = 0; k < NREQ; k++) begin
            if (!rst && ((gl >> k) & 1) == 1 && phead[k] < ptail[k]) phead[k]++;
        end
        v = '0;
        r = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (phead[k] < ptail[k]) begin
                r = r | (NREQ'(1) << k);
                v = v | ((NREQ*DW)'(pmem[k][phead[k] % 64]) << (k*DW));
            end
        end
        req      = r;
        req_data = v;
        ready    = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        @(negedge clk);
        g_lat = gnt;
    endtask

    task automatic hold_and_release();
        clear_producers();
        req      = '0;
        req_data = '0;
        g_lat    = '0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        g_lat = gnt;
    endtask

    // Scoreboard: every accepted word joins the queue; o_LEVEL must equal its size.
    logic [DW-1:0] sb [$];
    int            gnt_log [$];
    int            m_ptr;
    int            pop_cnt;
    int            gnt_cnt;

    always @(negedge clk) begin : cmp
        int              exp_k;
        int              kk;
        logic [NREQ-1:0] exp_g;
        logic [DW-1:0]   exp_di;
        logic [DW-1:0]   exp_pop;
        if (rst) begin
            m_ptr   = NREQ - 1;
            pop_cnt = 0;
            gnt_cnt = 0;
            sb.delete();
            gnt_log.delete();
            check("rst_valid", 32'(valid), 0);
            check("rst_data",  32'(data), 0);
            check("rst_gnt",   32'(gnt), 0);
            check("rst_wen",   32'(fifo_wen), 0);
            check("rst_ren",   32'(fifo_ren), 0);
            check("rst_level", 32'(level), 0);
        end else begin
            exp_k = -1;
            if (int'(fifo_cnt) != DEPTH) begin
                for (int off = 1; off <= NREQ; off++) begin
                    kk = (m_ptr + off) % NREQ;
                    if (exp_k < 0 && ((int'(req) >> kk) & 1) == 1) exp_k = kk;
                end
            end
            exp_g  = (exp_k >= 0) ? (NREQ'(1) << exp_k) : '0;
            exp_di = (exp_k >= 0) ? DW'(req_data >> (exp_k*DW)) : '0;
            check("gnt",   32'(gnt), 32'(exp_g));
            check("wen",   32'(fifo_wen), 32'(exp_k >= 0));
            check("di",    32'(fifo_di), 32'(exp_di));
            check("level", 32'(level), sb.size());
            check("ren_when_empty", 32'(fifo_ren && fifo_cnt == '0), 0);
            check("valid_without_word", 32'(valid && sb.size() == 0), 0);
            if (valid && ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_underflow: got 0x%0h required no word", data);
                end else begin
                    exp_pop = sb.pop_front();
                    check("data", 32'(data), 32'(exp_pop));
                    $display("pop   data=0x%04h exp=0x%04h level=%0d", data, exp_pop, level);
                end
                pop_cnt++;
            end
            if (exp_k >= 0) begin
                sb.push_back(exp_di);
                m_ptr = exp_k;
                gnt_cnt++;
                gnt_log.push_back(exp_k);
            end
        end
    end

    task automatic drain(input string name);
        bit done;
        rdy_mode = 1;
        done     = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            cycle();
            if (producers_empty() && level == '0 && !valid && sb.size() == 0) done = 1'b1;
        end
        check(name, 32'(done), 1);
    endtask

    logic [DW-1:0] sp_words [3];
    bit            found;
    bit            prev_ren;
    int            pk;

    initial begin
        sp_words[0] = 16'h0011;
        sp_words[1] = 16'h0022;
        sp_words[2] = 16'h0033;
        rst      = 1'b0;
        req      = '1;
        req_data = '1;
        ready    = 1'b0;
        rdy_mode = 0;
        g_lat    = '0;
        clear_producers();
        #1 rst = 1'b1;
        hold_and_release();

        // Idle after reset
        rdy_mode = 1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("idle_valid", 32'(valid), 0);
            check("idle_ren",   32'(fifo_ren), 0);
            check("idle_level", 32'(level), 0);
        end

        // Single producer: grant in cycles 0..2, words out in cycles 3..5
        for (int i = 0; i < 3; i++) push_word(1, sp_words[i]);
        for (int i = 0; i < 7; i++) begin
            cycle();
            check("sp_gnt",   32'(gnt), (i < 3) ? 32'h2 : 32'h0);
            check("sp_valid", 32'(valid), (i >= 3 && i <= 5) ? 32'h1 : 32'h0);
            if (i >= 3 && i <= 5) check("sp_data", 32'(data), 32'(sp_words[i-3]));
            if (i == 1) check("sp_ren", 32'(fifo_ren), 1);
        end
        drain("sp_drain");

        // Round robin with all producers busy
        rst = 1'b1;
        hold_and_release();
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < 8; i++) push_word(k, DW'(16'h1000 * (k + 1) + i));
        end
        for (int i = 0; i < 60 && gnt_cnt < 12; i++) cycle();
        check("rr_count", 32'(gnt_cnt >= 12), 1);
        for (int i = 0; i < 12 && i < gnt_log.size(); i++) check("rr_order", gnt_log[i], i % NREQ);
        drain("rr_drain");

        // Backpressure until full, then release
        rst = 1'b1;
        hold_and_release();
        rdy_mode = 0;
        for (int i = 0; i < 10; i++) push_word(0, DW'(16'h0100 + i));
        repeat (20) cycle();
        check("bp_gnt_total", gnt_cnt, 6);
        check("bp_level",     32'(level), 6);
        check("bp_gnt_held",  32'(gnt), 0);
        check("bp_valid",     32'(valid), 1);
        rdy_mode = 1;
        for (int i = 0; i < 30 && pop_cnt < 6; i++) cycle();
        check("bp_first6", 32'(pop_cnt >= 6), 1);
        drain("bp_drain");
        check("bp_gnt_resume", gnt_cnt, 10);

        // Random traffic with random backpressure
        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                pk = int'($urandom_range(0, NREQ - 1));
                if (ptail[pk] - phead[pk] < 40) push_word(pk, DW'($urandom));
            end
            cycle();
        end
        drain("rand_drain");

        // Reset while a word is buffered and a read is in flight
        for (int i = 0; i < 20; i++) push_word(0, DW'(16'h0200 + i));
        rdy_mode = 1;
        found    = 1'b0;
        prev_ren = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            cycle();
            if (valid && prev_ren) found = 1'b1;
            else prev_ren = fifo_ren;
        end
        check("mr_armed", 32'(found), 1);
        #1 rst = 1'b1;
        #1;
        check("mr_valid", 32'(valid), 0);
        check("mr_gnt",   32'(gnt), 0);
        check("mr_wen",   32'(fifo_wen), 0);
        check("mr_ren",   32'(fifo_ren), 0);
        check("mr_level", 32'(level), 0);
        check("mr_data",  32'(data), 0);
        hold_and_release();
        push_word(2, 16'h00A1);
        push_word(2, 16'h00A2);
        push_word(2, 16'h00A3);
        rdy_mode = 1;
        repeat (20) cycle();
        check("mr_pops",       pop_cnt, 3);
        check("mr_gnts",       gnt_cnt, 3);
        check("mr_level_end",  32'(level), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
